// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial controller.
// State encoding, ALU opcode map and the default overflow bound.
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DEC,
    DONE
  } fact_state_e;

  localparam logic [2:0] ALU_MUL = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_DEC = 3'b100;
  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_INC = 3'b111;

  localparam int FACT_MAX_N = 5;

endpackage

// File: rtl/fact_ctrl.sv
// Factorial controller: drives an external combinational ALU
// through alternating multiply/decrement steps to form n!.
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_N = FACT_MAX_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       sel_alu_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic [WIDTH-1:0] result_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_N);

  fact_state_e      state_q;
  fact_state_e      state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             last_dec;

  assign last_dec = (alu_result_i == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = (n_i >= TWO) ? MUL : DONE;
      MUL:  state_d = DEC;
      DEC:  state_d = last_dec ? DONE : MUL;
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_alu_o = ALU_MUL;
    alu_a_o   = '0;
    alu_b_o   = '0;
    unique case (state_q)
      MUL: begin
        alu_a_o = acc_q;
        alu_b_o = cnt_q;
      end
      DEC: begin
        sel_alu_o = ALU_DEC;
        alu_a_o   = cnt_q;
      end
      default: ;
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign result_o   = result_q;
  assign overflow_o = ovf_q;

  // n < 2 skips the loop, so its result (1) is loaded on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) begin
          acc_q    <= ONE;
          cnt_q    <= n_i;
          ovf_q    <= (n_i > MAX_W);
          result_q <= (n_i < TWO) ? ONE : '0;
        end
        MUL: acc_q <= alu_result_i;
        DEC: begin
          cnt_q <= alu_result_i;
          if (last_dec) result_q <= acc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fact_ctrl.md
# fact_ctrl

Control unit for the factorial datapath: it computes n! by sequencing the 8-bit ALU through alternating multiply and decrement operations. It drives the ALU operands and opcode, and captures the ALU result each cycle. It exposes a start/done handshake to the surrounding logic. The ALU sits beside it in `factorial_top`.

## Interface
- `WIDTH`, default 8: data width; must match the ALU.
- `MAX_N`, default 5: largest n whose n! fits in `WIDTH` bits; any larger n sets overflow.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_i` in 1: request; sampled only in IDLE.
- `n_i` in WIDTH: operand, latched when start is accepted.
- `alu_a_o` out WIDTH: ALU operand A.
- `alu_b_o` out WIDTH: ALU operand B.
- `sel_alu_o` out 3: ALU opcode.
- `alu_result_i` in WIDTH: ALU result, same cycle (ALU is combinational).
- `result_o` out WIDTH: n! mod 2^WIDTH; holds until the next accepted start.
- `done_o` out 1: one-cycle pulse when `result_o` is valid.
- `busy_o` out 1: high in every state except IDLE.
- `overflow_o` out 1: latched n > MAX_N; holds with `result_o`.

## Operation
- Registers: `acc` (WIDTH), `cnt` (WIDTH), `state`.
- Opcodes used: MUL = 3'b000 (A*B, truncated to WIDTH); DEC = 3'b100 (A-1).
- IDLE:
  - Outputs: `sel_alu_o` = 000, `alu_a_o` = `alu_b_o` = 0.
  - On `start_i`: `acc` <= 1, `cnt` <= `n_i`, `overflow_o` <= (`n_i` > MAX_N), `result_o` <= 0.
  - Next state is MUL if `n_i` >= 2, else DONE.
- MUL:
  - Drive `sel_alu_o` = MUL, a = `acc`, b = `cnt`.
  - `acc` <= `alu_result_i`; go to DEC.
- DEC:
  - Drive `sel_alu_o` = DEC, a = `cnt`, b = 0.
  - `cnt` <= `alu_result_i`.
  - If `alu_result_i` == 1, go to DONE; else go to MUL.
- DONE: `result_o` <= `acc` (registered on entry, so it is valid while `done_o` is high). `done_o` = 1; go to IDLE.
- Overflow handling: the product silently truncates. `overflow_o` only flags the condition and does not stop the computation.
- `start_i` outside IDLE is ignored. There is no queueing.

## Timing
- Reset value of every output: `result_o` = 0, `done_o` = 0, `busy_o` = 0, `overflow_o` = 0, `sel_alu_o` = 000, `alu_a_o` = `alu_b_o` = 0. State = IDLE, `acc` = 0, `cnt` = 0.
- Start is accepted at clock edge E0.
- Latency for n >= 2:
  - MUL occupies cycles 1, 3, …, 2n-3.
  - DEC occupies cycles 2, 4, …, 2n-2.
  - `done_o` is high in cycle 2n-1 after E0.
  - Back in IDLE in cycle 2n.
- Latency for n = 0 or n = 1: `done_o` is high in cycle 1; `result_o` = 1.
- Back-to-back: a new start may be sampled in the first IDLE cycle after DONE.
- `busy_o` and `done_o` are combinational from the registered state. All other outputs are either registered, or combinational from registered state and data only; none depends on inputs.
- Reset mid-operation: immediate abort to IDLE with all reset values. No `done_o` pulse.
- n = 255: valid, with 254 MUL/DEC pairs. `cnt` never wraps because the exit test fires at 1.

## Structure
- Shared package `fact_pkg` holds:
  - state enum IDLE/MUL/DEC/DONE;
  - opcode constants ALU_MUL = 3'b000, ALU_AND, ALU_XOR, ALU_OR, ALU_DEC = 3'b100, ALU_ADD, ALU_SUB, ALU_INC (full 3-bit map);
  - FACT_MAX_N = 5.
- `fact_ctrl` has no sub-modules: one FSM plus a datapath register block.
- The natural companion is `factorial_top`, which instantiates `fact_ctrl` and the ALU and wires operands, opcode and result.

## Test plan
- n=5, pulse start -> `result_o` = 0x78 (120), `done_o` high exactly 9 cycles after the accept edge, `overflow_o` = 0, opcode sequence 000,100 repeated 4 times.
- n=0, then n=1 -> `result_o` = 1, `done_o` in cycle 1, no MUL/DEC cycles observed.
- n=6 -> `result_o` = 0xD0 (720 mod 256), `overflow_o` = 1, done in cycle 11.
- n=3 with `start_i` held high and re-pulsed while busy -> a single result of 6 with a single done pulse. A new start in the IDLE cycle after DONE with n=4 -> 0x18.
- Reset asserted in cycle 4 of an n=5 run -> all outputs return to reset values asynchronously. No done pulse. A subsequent n=2 run returns 2 in cycle 3.
- n=255 -> completes with done in cycle 509 and `overflow_o` = 1. A scoreboard reference model of the truncated product matches `result_o`.
